// File: rtl/imager_crop.sv
// imager_crop -- window crop and decimation for a frame/line-valid pixel stream.
//
// Keeps a window of the upstream frame that starts at line row_offset and
// pixel col_offset. Within the window it keeps one line out of every
// row_skip+1 and one pixel out of every col_skip+1. It emits at most out_rows
// lines and at most out_cols pixels per line. Every output is registered, so
// the output stream lags the input by exactly one clock. fv follows fv_in for
// each frame the block accepts. lv and dat only carry the kept pixels.
//
// A frame is accepted only from its fv_in rising edge, and only while enable
// is high. The crop settings are captured at that edge and stay fixed for the
// whole frame.
//
// Optional feature, selected by the macro IMAGER_CROP_STATS_EN:
//   defined   -> meas_rows/meas_cols report the input line count of the last
//                accepted frame and the pixel count of its last line. They
//                update in the same cycle that frame_done rises.
//   undefined -> meas_rows/meas_cols are tied to 0.
//
// Ports:
//   clk, reset_n            clock (rising edge); async active-low reset
//   enable                  block runs while high
//   fv_in, lv_in, dat_in    upstream frame valid, line valid, pixel
//   row_offset, col_offset  first input line / pixel kept
//   out_rows, out_cols      maximum output lines per frame / pixels per line
//   row_skip, col_skip      keep 1 of every skip+1 lines / pixels
//   fv, lv, dat             registered cropped stream (dat is 0 when lv is low)
//   frame_done              one-cycle pulse after each accepted frame ends
//   meas_rows, meas_cols    measured input frame size (see macro above)

module imager_crop #(
   parameter int DATA_WIDTH     = 10,
   parameter int NUM_ROWS_WIDTH = 12,
   parameter int NUM_COLS_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      fv_in,
   input  logic                      lv_in,
   input  logic [DATA_WIDTH-1:0]     dat_in,
   input  logic [NUM_ROWS_WIDTH-1:0] row_offset,
   input  logic [NUM_COLS_WIDTH-1:0] col_offset,
   input  logic [NUM_ROWS_WIDTH-1:0] out_rows,
   input  logic [NUM_COLS_WIDTH-1:0] out_cols,
   input  logic [1:0]                row_skip,
   input  logic [1:0]                col_skip,
   output logic                      fv,
   output logic                      lv,
   output logic [DATA_WIDTH-1:0]     dat,
   output logic                      frame_done,
   output logic [NUM_ROWS_WIDTH:0]   meas_rows,
   output logic [NUM_COLS_WIDTH:0]   meas_cols
);

   localparam int RW = NUM_ROWS_WIDTH;
   localparam int CW = NUM_COLS_WIDTH;

   localparam logic [RW:0]   LINE_ONE = 1;
   localparam logic [RW-1:0] KROW_ONE = 1;
   localparam logic [CW:0]   COL_ONE  = 1;
   localparam logic [CW-1:0] KCOL_ONE = 1;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t state, state_next;

   // Saturating increments: counters stop at all-ones instead of wrapping.
   function automatic logic [RW:0] inc_line(input logic [RW:0] x);
      return (&x) ? x : x + LINE_ONE;
   endfunction

   function automatic logic [RW-1:0] inc_krow(input logic [RW-1:0] x);
      return (&x) ? x : x + KROW_ONE;
   endfunction

   function automatic logic [CW:0] inc_col(input logic [CW:0] x);
      return (&x) ? x : x + COL_ONE;
   endfunction

   function automatic logic [CW-1:0] inc_kcol(input logic [CW-1:0] x);
      return (&x) ? x : x + KCOL_ONE;
   endfunction

   // Phase counter that replaces the modulo test. It cycles 0..skip, and
   // phase 0 marks a line or pixel that is kept.
   function automatic logic [1:0] next_phase(input logic [1:0] p, input logic [1:0] skip);
      return (p == skip) ? 2'd0 : p + 2'd1;
   endfunction

   // Previous-cycle copies of the upstream strobes, used for edge detection.
   logic fv_in_p1;
   logic lv_in_p1;

   // Crop settings captured when a frame is accepted.
   logic [RW-1:0] cfg_row_offset, cfg_out_rows;
   logic [CW-1:0] cfg_col_offset, cfg_out_cols;
   logic [1:0]    cfg_row_skip, cfg_col_skip;

   logic [RW:0]   line_cnt;
   logic [1:0]    row_phase;
   logic [RW-1:0] kept_rows;
   logic [CW:0]   col_cnt;
   logic [1:0]    col_phase;
   logic [CW-1:0] kept_cols;

   logic          fv_rise, fv_fall, entering, run, lv_act, lv_rise, lv_fall, frame_end;
   logic [RW-1:0] c_row_offset, c_out_rows;
   logic [CW-1:0] c_col_offset, c_out_cols;
   logic [1:0]    c_row_skip, c_col_skip;
   logic [RW:0]   cur_line;
   logic [1:0]    cur_row_phase;
   logic [RW-1:0] cur_kept_rows;
   logic [CW:0]   cur_col;
   logic [1:0]    cur_col_phase;
   logic [CW-1:0] cur_kept_cols;
   logic          line_ge, line_keep, col_ge, pix_keep;

   always_comb begin
      fv_rise   = fv_in & ~fv_in_p1;
      fv_fall   = ~fv_in & fv_in_p1;
      entering  = (state == IDLE) & enable & fv_rise;
      run       = enable & fv_in & ((state == ACTIVE) | entering);
      // lv_in is ignored outside an accepted frame.
      lv_act    = run & lv_in;
      lv_rise   = lv_act & ~lv_in_p1;
      lv_fall   = (state == ACTIVE) & lv_in_p1 & ~lv_act;
      frame_end = enable & (state == ACTIVE) & fv_fall;

      // In the capture cycle the latched settings are not loaded yet, so the
      // port values are used directly.
      c_row_offset = (state == IDLE) ? row_offset : cfg_row_offset;
      c_col_offset = (state == IDLE) ? col_offset : cfg_col_offset;
      c_out_rows   = (state == IDLE) ? out_rows   : cfg_out_rows;
      c_out_cols   = (state == IDLE) ? out_cols   : cfg_out_cols;
      c_row_skip   = (state == IDLE) ? row_skip   : cfg_row_skip;
      c_col_skip   = (state == IDLE) ? col_skip   : cfg_col_skip;

      // Line state reads as zero until the frame is active. This avoids
      // depending on a clear from the previous frame, which matters when
      // fv_in is low for only one cycle between frames.
      cur_line      = (state == IDLE) ? '0 : line_cnt;
      cur_row_phase = (state == IDLE) ? '0 : row_phase;
      cur_kept_rows = (state == IDLE) ? '0 : kept_rows;

      // The first lv_in pixel of a line is column 0.
      cur_col       = lv_rise ? '0 : col_cnt;
      cur_col_phase = lv_rise ? '0 : col_phase;
      cur_kept_cols = lv_rise ? '0 : kept_cols;

      line_ge   = ({1'b0, c_row_offset} <= cur_line);
      line_keep = line_ge & (cur_row_phase == 2'd0) & (cur_kept_rows < c_out_rows);
      col_ge    = ({1'b0, c_col_offset} <= cur_col);
      pix_keep  = lv_act & line_keep & col_ge & (cur_col_phase == 2'd0) &
                  (cur_kept_cols < c_out_cols);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (entering) state_next = ACTIVE;
         ACTIVE:  if (!enable || fv_fall) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // fv_in_p1 resets high. If fv_in is still high when reset is released,
   // no rising edge is seen, and the block waits for the next frame instead
   // of joining one that is already in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         fv_in_p1   <= 1'b1;
         lv_in_p1   <= 1'b0;
         fv         <= 1'b0;
         lv         <= 1'b0;
         dat        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         fv_in_p1   <= fv_in;
         lv_in_p1   <= lv_act;
         fv         <= run;
         lv         <= pix_keep;
         dat        <= pix_keep ? dat_in : '0;
         frame_done <= frame_end;
      end
   end

   always_ff @(posedge clk) begin
      if (entering) begin
         cfg_row_offset <= row_offset;
         cfg_col_offset <= col_offset;
         cfg_out_rows   <= out_rows;
         cfg_out_cols   <= out_cols;
         cfg_row_skip   <= row_skip;
         cfg_col_skip   <= col_skip;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_cnt  <= '0;
         row_phase <= '0;
         kept_rows <= '0;
         col_cnt   <= '0;
         col_phase <= '0;
         kept_cols <= '0;
      end else begin
         if (entering) begin
            line_cnt  <= '0;
            row_phase <= '0;
            kept_rows <= '0;
         end else if (lv_fall) begin
            line_cnt <= inc_line(line_cnt);
            // The row phase only starts to advance at row_offset.
            if (line_ge) begin
               row_phase <= next_phase(row_phase, c_row_skip);
               if (line_keep) kept_rows <= inc_krow(kept_rows);
            end
         end
         if (lv_act) begin
            col_cnt <= inc_col(cur_col);
            if (col_ge) begin
               col_phase <= next_phase(cur_col_phase, c_col_skip);
               kept_cols <= pix_keep ? inc_kcol(cur_kept_cols) : cur_kept_cols;
            end else begin
               col_phase <= cur_col_phase;
               kept_cols <= cur_kept_cols;
            end
         end
      end
   end

`ifdef IMAGER_CROP_STATS_EN
   // Sampled on the fv_in falling edge. A line that ends in the same cycle
   // is still included.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meas_rows <= '0;
         meas_cols <= '0;
      end else if (frame_end) begin
         meas_rows <= lv_fall ? inc_line(line_cnt) : line_cnt;
         meas_cols <= col_cnt;
      end
   end
`else
   assign meas_rows = '0;
   assign meas_cols = '0;
`endif

endmodule

// File: tb/tb_imager_crop.sv
module tb_imager_crop;

   logic        clk = 1'b0;
   logic        reset_n, enable, fv_in, lv_in;
   logic [9:0]  dat_in;
   logic [11:0] row_offset, col_offset, out_rows, out_cols;
   logic [1:0]  row_skip, col_skip;
   logic        fv, lv, frame_done;
   logic [9:0]  dat;
   logic [12:0] meas_rows, meas_cols;

   imager_crop dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .fv_in      (fv_in),
      .lv_in      (lv_in),
      .dat_in     (dat_in),
      .row_offset (row_offset),
      .col_offset (col_offset),
      .out_rows   (out_rows),
      .out_cols   (out_cols),
      .row_skip   (row_skip),
      .col_skip   (col_skip),
      .fv         (fv),
      .lv         (lv),
      .dat        (dat),
      .frame_done (frame_done),
      .meas_rows  (meas_rows),
      .meas_cols  (meas_cols)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] d;
      int         c;
   } exp_t;

   typedef struct {
      string name;
      int    act;
      int    exp;
   } chk_t;

   exp_t sb_q[$];
   chk_t chk_q[$];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int fv_cnt = 0;
   int lv_cnt = 0;
   int fd_cnt = 0;
   int ro, co, orow, ocol, rs, cs;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the pixel scoreboard whenever lv is high and checks both
   // the value and the one-cycle latency. It also evaluates queued checks.
   exp_t e;
   chk_t r;
   always @(negedge clk) begin
      if (fv) fv_cnt++;
      if (frame_done) fd_cnt++;
      n_tests++;
      if (lv) begin
         lv_cnt++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL lv_unexpected: dat=%0d at cycle %0d, no pixel expected", dat, cyc);
         end else begin
            e = sb_q.pop_front();
            if (dat !== e.d || cyc != e.c + 1) begin
               n_fail++;
               $display("FAIL pixel: got dat=%0d at cycle %0d, expected dat=%0d at cycle %0d",
                        dat, cyc, e.d, e.c + 1);
            end
         end
      end else if (dat !== 10'd0) begin
         n_fail++;
         $display("FAIL dat_idle: got dat=%0d with lv low, expected 0", dat);
      end
      while (chk_q.size() > 0) begin
         r = chk_q.pop_front();
         n_tests++;
         if (r.act != r.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", r.name, r.act, r.exp);
         end
      end
   end

   task automatic chk(input string name, input int act, input int expv);
      chk_q.push_back('{name, act, expv});
   endtask

   task automatic set_cfg(input int a, input int b, input int c, input int d,
                          input int f, input int g);
      ro = a; co = b; orow = c; ocol = d; rs = f; cs = g;
      row_offset = 12'(a); col_offset = 12'(b);
      out_rows   = 12'(c); out_cols   = 12'(d);
      row_skip   = 2'(f);  col_skip   = 2'(g);
   endtask

   function automatic bit kept(input int l, input int c);
      int rl, cl;
      if (l < ro || c < co) return 1'b0;
      rl = l - ro;
      cl = c - co;
      return (rl % (rs + 1) == 0) && (rl / (rs + 1) < orow) &&
             (cl % (cs + 1) == 0) && (cl / (cs + 1) < ocol);
   endfunction

   task automatic drive(input logic f, input logic l, input logic [9:0] d);
      @(posedge clk);
      #1;
      fv_in = f; lv_in = l; dat_in = d;
   endtask

   task automatic run_frame(input int rows, input int cols, input int base, input bit exp_on_i,
                            input int en_line, input int rst_line, input int exp_lv,
                            input int exp_fd, input int exp_fv, input string tag);
      bit         exp_on;
      bit         rst_pending;
      int         s_fv, s_lv, s_fd;
      logic [9:0] pix;
      exp_on = exp_on_i;
      rst_pending = 1'b0;
      s_fv = fv_cnt; s_lv = lv_cnt; s_fd = fd_cnt;
      repeat (2) drive(1'b1, 1'b0, 10'd0);
      for (int l = 0; l < rows; l++) begin
         if (l == en_line) enable = 1'b1;
         for (int c = 0; c < cols; c++) begin
            pix = 10'((base + l * 16 + c) % 1024);
            drive(1'b1, 1'b1, pix);
            if (rst_pending) begin
               reset_n = 1'b1;
               rst_pending = 1'b0;
            end
            if (exp_on && kept(l, c)) sb_q.push_back('{pix, cyc});
            if (l == rst_line && c == cols / 2) begin
               reset_n = 1'b0;
               #1;
               chk({tag, "_rst_fv"}, int'(fv), 0);
               chk({tag, "_rst_lv"}, int'(lv), 0);
               chk({tag, "_rst_dat"}, int'(dat), 0);
               sb_q.delete();
               exp_on = 1'b0;
               rst_pending = 1'b1;
               s_fv = fv_cnt; s_lv = lv_cnt; s_fd = fd_cnt;
            end
         end
         repeat (3) drive(1'b1, 1'b0, 10'd0);
      end
      repeat (4) drive(1'b0, 1'b0, 10'd0);
      chk({tag, "_lv_cycles"}, lv_cnt - s_lv, exp_lv);
      chk({tag, "_frame_done"}, fd_cnt - s_fd, exp_fd);
      chk({tag, "_fv_cycles"}, fv_cnt - s_fv, exp_fv);
      chk({tag, "_sb_left"}, sb_q.size(), 0);
   endtask

   initial begin
      int s_lv;
      reset_n = 1'b0; enable = 1'b0; fv_in = 1'b0; lv_in = 1'b0; dat_in = 10'd0;
      set_cfg(0, 0, 8, 16, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_fv", int'(fv), 0);
      chk("reset_lv", int'(lv), 0);
      chk("reset_dat", int'(dat), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_meas_rows", int'(meas_rows), 0);
      chk("reset_meas_cols", int'(meas_cols), 0);
      reset_n = 1'b1;
      enable = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 10'd0);

      // Full pass-through: 8x16, 128 pixels, fv = 2 + 8*19 cycles.
      set_cfg(0, 0, 8, 16, 0, 0);
      run_frame(8, 16, 0, 1'b1, -1, -1, 128, 1, 154, "passthru");

      // Window lines 2-4, pixels 4-8: 15 pixels.
      set_cfg(2, 4, 3, 5, 0, 0);
      run_frame(8, 16, 200, 1'b1, -1, -1, 15, 1, 154, "window");

      // Decimate by 2 in both directions: 4 lines x 8 pixels.
      set_cfg(0, 0, 8, 16, 1, 1);
      run_frame(8, 16, 400, 1'b1, -1, -1, 32, 1, 154, "skip");

      // lv_in while fv_in is low must be ignored.
      s_lv = lv_cnt;
      repeat (3) drive(1'b0, 1'b1, 10'd55);
      repeat (3) drive(1'b0, 1'b0, 10'd0);
      chk("lv_without_fv", lv_cnt - s_lv, 0);

      // out_rows = 0: frame passes with no lines. fv = 2 + 4*11 cycles.
      set_cfg(0, 0, 0, 16, 0, 0);
      run_frame(4, 8, 600, 1'b1, -1, -1, 0, 1, 46, "zero_rows");

      // Row offset beyond the frame.
      set_cfg(20, 0, 8, 16, 0, 0);
      run_frame(4, 8, 700, 1'b1, -1, -1, 0, 1, 46, "far_offset");

      // Enable raised mid-frame: nothing that frame, next frame passes fully.
      set_cfg(0, 0, 8, 16, 0, 0);
      enable = 1'b0;
      run_frame(8, 16, 800, 1'b0, 3, -1, 0, 0, 0, "en_mid");
      run_frame(8, 16, 900, 1'b1, -1, -1, 128, 1, 154, "after_en");

      // Reset pulsed mid-line, then a full frame.
      run_frame(8, 16, 100, 1'b1, -1, 3, 0, 0, 0, "rst_mid");
      run_frame(8, 16, 300, 1'b1, -1, -1, 128, 1, 154, "after_rst");

      // 6x10 frame for the measurement outputs: fv = 2 + 6*13 cycles.
      run_frame(6, 10, 500, 1'b1, -1, -1, 60, 1, 80, "stats");
`ifdef IMAGER_CROP_STATS_EN
      chk("meas_rows", int'(meas_rows), 6);
      chk("meas_cols", int'(meas_cols), 10);
`else
      chk("meas_rows", int'(meas_rows), 0);
      chk("meas_cols", int'(meas_cols), 0);
`endif

      repeat (3) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imager_crop.md
IMAGER_CROP -- requirements
Module: imager_crop

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, pixel width.
REQ-002 SHALL have parameter NUM_ROWS_WIDTH, default 12, row counter/config width.
REQ-003 SHALL have parameter NUM_COLS_WIDTH, default 12, column counter/config width.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  block runs while high.
- fv_in  in  1  frame valid from upstream pixel source.
- lv_in  in  1  line valid from upstream; qualifies dat_in.
- dat_in  in  DATA_WIDTH  upstream pixel.
- row_offset  in  NUM_ROWS_WIDTH  first input line kept.
- col_offset  in  NUM_COLS_WIDTH  first input pixel of a line kept.
- out_rows  in  NUM_ROWS_WIDTH  max output lines per frame.
- out_cols  in  NUM_COLS_WIDTH  max output pixels per line.
- row_skip  in  2  keep 1 of every row_skip+1 lines.
- col_skip  in  2  keep 1 of every col_skip+1 pixels.
- fv  out  1  registered frame valid.
- lv  out  1  registered line valid of cropped stream.
- dat  out  DATA_WIDTH  cropped pixel; 0 when lv low.
- frame_done  out  1  one-cycle pulse at end of each passed frame.
- meas_rows  out  NUM_ROWS_WIDTH+1  measured input lines of last frame.
- meas_cols  out  NUM_COLS_WIDTH+1  measured input pixels of last line of last frame.

Function
REQ-005 SHALL have two states: IDLE, ACTIVE.
REQ-006 IDLE -> ACTIVE on an fv_in 0->1 edge (fv_in low previous cycle, high current) with enable high; never enter mid-frame.
REQ-007 ACTIVE -> IDLE on fv_in 1->0 edge; frame_done pulses high the following cycle.
REQ-008 On entering ACTIVE, SHALL latch row_offset, col_offset, out_rows, out_cols, row_skip, col_skip; changes mid-frame take effect next frame.
REQ-009 Input line counter: cleared on fv_in rise, +1 on each lv_in 1->0 edge; input column counter: cleared on lv_in 0->1 rise (first lv pixel = column 0), +1 per lv_in cycle.
REQ-010 Line kept iff line >= row_offset, (line-row_offset) mod (row_skip+1)==0, and kept-line count < out_rows; use phase counters, no dividers.
REQ-011 Pixel kept iff its line kept, col >= col_offset, (col-col_offset) mod (col_skip+1)==0, and kept-pixel count in line < out_cols.
REQ-012 Latency exactly 1 cycle: fv <= fv_in (ACTIVE or entering), lv <= lv_in & kept, dat <= kept ? dat_in : 0.
REQ-013 Output lv MAY be non-contiguous when col_skip>0; fv stays high across the whole input frame.
REQ-014 out_rows==0 or out_cols==0 or offsets beyond frame: fv passes, lv never asserts, frame_done still pulses.
REQ-015 lv_in high while fv_in low SHALL be ignored (no counting, lv stays 0).
REQ-016 Counters saturate at all-ones; no wrap.
REQ-017 enable low: fv, lv, dat, frame_done 0 next cycle; state IDLE; meas_* hold.
REQ-018 Frame in progress when enable rises: block stays IDLE until the next fv_in rise.

Reset
REQ-019 Asynchronous reset: state IDLE, all counters 0, fv=0, lv=0, dat=0, frame_done=0, meas_rows=0, meas_cols=0.
REQ-020 Reset mid-frame: outputs drop immediately; after release, wait for next fv_in rise.

Configuration
REQ-021 Macro IMAGER_CROP_STATS_EN defined: meas_rows/meas_cols updated on frame_done cycle with input line count and last line pixel count of that frame.
REQ-022 Macro undefined: meas_rows and meas_cols tied to 0; measurement logic absent; ports remain.

Verification
REQ-023 Upstream frame 8 lines x 16 pixels, offsets 0, skips 0, out 8x16 -> output identical to input delayed 1 cycle, frame_done once.
REQ-024 Same frame, row_offset=2, col_offset=4, out_rows=3, out_cols=5 -> lines 2-4, pixels 4-8 of each kept; 15 lv cycles total.
REQ-025 col_skip=1, row_skip=1, offsets 0, out 8x16 -> lines 0,2,4,6, pixels 0,2,...,14; 32 lv cycles.
REQ-026 Enable raised mid-frame -> no lv that frame; next frame passed fully.
REQ-027 IMAGER_CROP_STATS_EN defined, 6x10 frame -> meas_rows=6, meas_cols=10 after frame_done; undefined -> both 0.
REQ-028 reset_n pulsed mid-line -> fv/lv/dat 0 immediately; next full frame passes correctly.
